// File: rtl/dcache_ctrl.sv
// dcache_ctrl: 8 x 4-byte direct-mapped, write-back, write-allocate data cache controller
module dcache_ctrl (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);
  typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH, UPDATE} state_t;
  state_t state, state_nx;
  logic [7:0]  valid, dirty;
  logic [2:0]  tag [8];
  logic [31:0] data [8];
  logic [2:0]  a_tag, a_idx;
  logic [1:0]  a_off;
  logic        hit, req;
  assign a_tag = ADDRESS[7:5];
  assign a_idx = ADDRESS[4:2];
  assign a_off = ADDRESS[1:0];
  assign hit = valid[a_idx] && tag[a_idx] == a_tag;
  assign req = READ | WRITE;
  assign READDATA = READ ? data[a_idx][{a_off, 3'b000} +: 8] : 8'h00;
  always_comb begin
    state_nx = state;
    BUSYWAIT = 1'b1;
    MEM_READ = 1'b0;
    MEM_WRITE = 1'b0;
    MEM_ADDRESS = {a_tag, a_idx};
    MEM_WRITEDATA = data[a_idx];
    case (state)
      IDLE: begin
        BUSYWAIT = req && !hit;
        state_nx = (!req || hit) ? IDLE : (valid[a_idx] && dirty[a_idx]) ? WRITE_BACK : FETCH;
      end
      WRITE_BACK: begin
        MEM_WRITE = 1'b1;
        MEM_ADDRESS = {tag[a_idx], a_idx};
        state_nx = MEM_BUSYWAIT ? WRITE_BACK : FETCH;
      end
      FETCH: begin
        MEM_READ = 1'b1;
        state_nx = MEM_BUSYWAIT ? FETCH : UPDATE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // tag/data arrays are deliberately left uncleared by reset; valid gates their use
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nx;
      if (state == UPDATE) begin
        data[a_idx]  <= MEM_READDATA;
        tag[a_idx]   <= a_tag;
        valid[a_idx] <= 1'b1;
        dirty[a_idx] <= 1'b0;
      end else if (state == IDLE && WRITE && hit) begin
        data[a_idx][{a_off, 3'b000} +: 8] <= WRITEDATA;
        dirty[a_idx] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench; the reference is a flat byte-addressed memory image the cache must stay transparent to
module tb_dcache_ctrl;
  logic        CLK = 0, RESET, READ, WRITE, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;
  int total = 0, bad = 0, lat = 3, cnt = 0;
  bit [31:0] mem_q [64];
  bit        mem_w [64];
  logic [7:0] ref_b [256];
  logic [7:0] exp_q [$];

  dcache_ctrl dut (.CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT));

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [5:0] w);
    return mem_w[w] ? mem_q[w] : (w == 6'h09) ? 32'hDDCCBBAA : 32'h9E3779B9 * (32'(w) + 1);
  endfunction

  function automatic logic [31:0] ref_word(input logic [5:0] w);
    return {ref_b[{w, 2'd3}], ref_b[{w, 2'd2}], ref_b[{w, 2'd1}], ref_b[{w, 2'd0}]};
  endfunction

  // memory: busy for lat cycles from the cycle a request appears, then one completing cycle
  assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && cnt < lat;
  assign MEM_READDATA = mem_word(MEM_ADDRESS);
  always @(posedge CLK) begin
    if (MEM_READ || MEM_WRITE) begin
      if (!MEM_BUSYWAIT) begin
        cnt <= 0;
        if (MEM_WRITE) begin
          mem_q[MEM_ADDRESS] <= MEM_WRITEDATA;
          mem_w[MEM_ADDRESS] <= 1'b1;
        end
      end else cnt <= cnt + 1;
    end else cnt <= 0;
  end

  always @(negedge CLK) begin
    if (RESET && READ && !WRITE && !BUSYWAIT) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rdata: got %h with no expected entry", READDATA);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (READDATA !== e) begin
          bad++;
          $display("FAIL rdata @%h: got %h expected %h", ADDRESS, READDATA, e);
        end
      end
    end else if (!READ) begin
      total++;
      if (READDATA !== 8'h00) begin
        bad++;
        $display("FAIL rdata_idle: got %h expected 00", READDATA);
      end
    end
    if (MEM_READ || MEM_WRITE) begin
      total++;
      if (MEM_READ && MEM_WRITE) begin
        bad++;
        $display("FAIL mem_excl: MEM_READ=1 MEM_WRITE=1 expected one-hot");
      end
    end
    if (MEM_WRITE && !MEM_BUSYWAIT) begin
      total++;
      if (MEM_WRITEDATA !== ref_word(MEM_ADDRESS)) begin
        bad++;
        $display("FAIL wb_data @%h: got %h expected %h", MEM_ADDRESS, MEM_WRITEDATA, ref_word(MEM_ADDRESS));
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic resync();
    for (int a = 0; a < 256; a++) ref_b[a] = mem_word(a[7:2]) >> (8 * a[1:0]);
  endtask

  int st, nw, nf;
  logic [5:0] wa, fa;
  logic [31:0] wd;

  // issue one request (called at posedge+1), hold it until BUSYWAIT is low at a negedge
  task automatic do_req(input bit rd, input bit wr, input logic [7:0] a, input logic [7:0] d);
    bit done = 0;
    st = 0; nw = 0; nf = 0; wa = '0; fa = '0; wd = '0;
    ADDRESS = a; WRITEDATA = d; READ = rd; WRITE = wr;
    if (rd && !wr) exp_q.push_back(ref_b[a]);
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK);
      if (MEM_WRITE) begin wa = MEM_ADDRESS; wd = MEM_WRITEDATA; if (!MEM_BUSYWAIT) nw++; end
      if (MEM_READ) begin fa = MEM_ADDRESS; if (!MEM_BUSYWAIT) nf++; end
      if (!BUSYWAIT) done = 1; else st++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL timeout: request @%h still stalled after 60 cycles", a);
    end
    if (wr) ref_b[a] = d;
    @(posedge CLK); #1;
    READ = 0; WRITE = 0;
  endtask

  initial begin
    int n;
    RESET = 0; READ = 0; WRITE = 0; ADDRESS = 0; WRITEDATA = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", BUSYWAIT, 0);
    chk("rst_mrd", MEM_READ, 0);
    chk("rst_mwr", MEM_WRITE, 0);
    RESET = 1;
    resync();
    @(posedge CLK); #1;
    do_req(1, 0, 8'h25, 0);
    chk("r24_stall", st, 6); chk("r24_faddr", fa, 6'h09); chk("r24_nf", nf, 1); chk("r24_nw", nw, 0);
    do_req(0, 1, 8'h27, 8'h5A);
    chk("r25_wstall", st, 0); chk("r25_wnf", nf, 0);
    do_req(1, 0, 8'h27, 0);
    chk("r25_rstall", st, 0);
    do_req(1, 0, 8'h45, 0);
    chk("r26_stall", st, 10); chk("r26_nw", nw, 1); chk("r26_waddr", wa, 6'h09);
    chk("r26_wdata", wd, 32'h5ACCBBAA); chk("r26_faddr", fa, 6'h11); chk("r26_nf", nf, 1);
    do_req(1, 0, 8'h45, 0);
    chk("r26_hit", st, 0);
    do_req(0, 1, 8'h80, 8'h3C);
    chk("r27_stall", st, 6); chk("r27_nf", nf, 1); chk("r27_nw", nw, 0);
    do_req(1, 0, 8'h80, 0);
    chk("r27_hit", st, 0);
    do_req(1, 0, 8'hA0, 0);
    chk("r27_evict_nw", nw, 1); chk("r27_evict_addr", wa, 6'h20); chk("r27_evict_b0", wd[7:0], 8'h3C);
    ADDRESS = 8'h0C; READ = 1; WRITE = 0;
    n = 0;
    while (!MEM_READ && n < 20) begin @(negedge CLK); n++; end
    chk("r28_fetch", MEM_READ, 1);
    RESET = 0;
    @(posedge CLK); #1;
    READ = 0;
    @(negedge CLK);
    chk("r28_mrd", MEM_READ, 0); chk("r28_mwr", MEM_WRITE, 0); chk("r28_busy", BUSYWAIT, 0);
    RESET = 1;
    @(posedge CLK); #1;
    resync();
    do_req(1, 0, 8'h0C, 0);
    chk("r28_remiss", st, 6); chk("r28_nf", nf, 1);
    do_req(1, 0, 8'h80, 0);
    chk("r28_lost_nw", nw, 0);
    do_req(1, 1, 8'h0D, 8'h77);
    chk("r29_stall", st, 0); chk("r29_nf", nf, 0); chk("r29_nw", nw, 0);
    do_req(1, 0, 8'h2D, 0);
    chk("r29_evict_nw", nw, 1); chk("r29_evict_addr", wa, 6'h03); chk("r29_evict_b1", wd[15:8], 8'h77);
    for (int i = 0; i < 300; i++) begin
      int op, l;
      l = $urandom_range(1, 3);
      lat = l;
      op = $urandom_range(0, 2);
      do_req(op != 1, op != 0, 8'($urandom) & 8'h7F, 8'($urandom));
      chk("rnd_stall", (st == 0 || st == l + 3 || st == 2 * l + 4), 1);
    end
    repeat (2) @(posedge CLK);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 8 blocks x 4 bytes, direct-mapped, write-back, write-allocate.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  reset; synchronous, active-low.
- READ  in  1  CPU load request.
- WRITE  in  1  CPU store request.
- ADDRESS  in  8  byte address (ALU result): tag[7:5], index[4:2], offset[1:0].
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  block fetch request.
- MEM_WRITE  out  1  block write-back request.
- MEM_ADDRESS  out  6  block address {tag, index}.
- MEM_WRITEDATA  out  32  write-back block; byte n at bits [8n+7:8n].
- MEM_READDATA  in  32  fetched block, same byte order.
- MEM_BUSYWAIT  in  1  memory busy.

Function
REQ-003 Per block state SHALL be: valid (1b), dirty (1b), tag (3b), data (32b).
REQ-004 Hit SHALL be combinational: valid[index] AND tag[index]==ADDRESS[7:5].
REQ-005 FSM states SHALL be IDLE, WRITE_BACK, FETCH, UPDATE.
REQ-006 IDLE, READ high, hit: READDATA = data[index] byte [offset] combinationally, BUSYWAIT=0; zero-stall hit.
REQ-007 IDLE, WRITE high, hit: the byte SHALL be written and dirty set at the next edge, BUSYWAIT=0.
REQ-008 IDLE, request, miss, block clean or invalid: BUSYWAIT=1 combinationally; next state FETCH.
REQ-009 IDLE, request, miss, valid and dirty: BUSYWAIT=1; next state WRITE_BACK.
REQ-010 WRITE_BACK: MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=data[index]; next state FETCH on the first edge with MEM_BUSYWAIT=0, else hold.
REQ-011 FETCH: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2]; next state UPDATE on the first edge with MEM_BUSYWAIT=0, else hold.
REQ-012 UPDATE: at the edge leaving UPDATE, the block SHALL capture data=MEM_READDATA, tag=ADDRESS[7:5], valid=1, dirty=0; next state IDLE unconditionally.
REQ-013 BUSYWAIT SHALL be 1 in every state other than IDLE; in IDLE the pending request then completes as a hit per REQ-006/007.
REQ-014 MEM_READ and MEM_WRITE SHALL be Moore outputs of state, never both 1, and 0 in IDLE and UPDATE.
REQ-015 Memory contract: memory raises MEM_BUSYWAIT in the same cycle MEM_READ/MEM_WRITE rises and drops it for the completing cycle; MEM_READDATA is valid in that cycle.
REQ-016 CPU contract: READ, WRITE, ADDRESS, WRITEDATA are held stable while BUSYWAIT=1.
REQ-017 READ and WRITE both high SHALL be treated as WRITE.
REQ-018 Neither READ nor WRITE high in IDLE: BUSYWAIT=0, no state change.
REQ-019 A write miss SHALL allocate: fetch the block, then perform the write hit in IDLE, leaving dirty=1.
REQ-020 READDATA SHALL hold 8'h00 when READ is low.

Reset
REQ-021 With RESET=0 at an edge: state=IDLE, all valid=0, all dirty=0; tag and data arrays are not cleared.
REQ-022 During and after reset, outputs SHALL be BUSYWAIT=0 (absent a request), MEM_READ=0, MEM_WRITE=0.
REQ-023 Reset mid-transaction SHALL abort to IDLE next edge; dirty data is discarded and the block is invalid.

Verification
REQ-024 After reset, READ ADDRESS=8'h25 -> BUSYWAIT=1, FETCH with MEM_ADDRESS=6'h09; memory returns 32'hDDCCBBAA after 3 busy cycles -> UPDATE, then IDLE with READDATA=8'hBB, BUSYWAIT=0.
REQ-025 Following that, WRITE 8'h5A to 8'h27 -> no stall, block 1 dirty; READ 8'h27 -> READDATA=8'h5A with zero stall.
REQ-026 Then READ 8'h45 (same index, tag 2) -> WRITE_BACK with MEM_ADDRESS=6'h09, MEM_WRITEDATA=32'h5ACCBBAA, then FETCH with MEM_ADDRESS=6'h11, then hit.
REQ-027 WRITE miss to clean block 8'h80 -> FETCH, UPDATE, write hit; block ends valid=1, dirty=1, byte 0 equal to WRITEDATA.
REQ-028 RESET=0 asserted during FETCH -> next edge IDLE, MEM_READ=0; subsequent READ of the same address misses again.
REQ-029 READ and WRITE both high on a hit -> write performed, dirty=1, no memory traffic.
